// File: rtl/mem_stall_pkg.sv
// mem_stall_pkg: shared state encoding and defaults for the memory stall controller
package mem_stall_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;
   localparam int TIMEOUT_DEF = 64;
   localparam int TW = 6;
endpackage

// File: rtl/mem_stall_if.sv
// mem_stall_if: pipeline request, memory handshake and status signals of the stall controller
interface mem_stall_if;
   logic memRead_in, memWrite_in, mem_stall, mem_done, mem_hit;
   logic [15:0] addr_in, wdata_in, mem_rdata;
   logic mem_rd, mem_wr, mem_freeze, done_pulse, err;
   logic [15:0] mem_addr, mem_wdata, rdata_out, hit_cnt, miss_cnt;
   modport master (
      input memRead_in, memWrite_in, addr_in, wdata_in, mem_stall, mem_done, mem_hit, mem_rdata,
      output mem_rd, mem_wr, mem_addr, mem_wdata, mem_freeze, rdata_out, done_pulse, hit_cnt, miss_cnt, err
   );
   modport slave (
      output memRead_in, memWrite_in, addr_in, wdata_in, mem_stall, mem_done, mem_hit, mem_rdata,
      input mem_rd, mem_wr, mem_addr, mem_wdata, mem_freeze, rdata_out, done_pulse, hit_cnt, miss_cnt, err
   );
endinterface

// File: rtl/mem_stall_ctrl_sat_cnt16.sv
// sat_cnt16: 16-bit counter with enable that sticks at all-ones
module sat_cnt16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] q
);
   always_ff @(posedge clk)
      if (rst) q <= '0;
      else if (en && q != 16'hFFFF) q <= q + 16'd1;
endmodule

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: launches each MEM-stage access once and freezes the pipeline until it completes
module mem_stall_ctrl
   import mem_stall_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input logic         clk,
   input logic         rst,
   mem_stall_if.master m
);
   state_t state, state_nx;
   logic op_rd, err_q, req, fin, tout;
   logic [TW-1:0] tcnt;
   logic [15:0] addr_q, wdata_q, rdata_q;
   assign req = m.memRead_in | m.memWrite_in;
   assign fin = (state == ST_ISSUE && !m.mem_stall && m.mem_done) || (state == ST_WAIT && m.mem_done);
   assign tout = state == ST_WAIT && !m.mem_done && tcnt == TW'(TIMEOUT - 1);
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  state_nx = req ? ST_ISSUE : ST_IDLE;
         ST_ISSUE: state_nx = m.mem_stall ? ST_ISSUE : (m.mem_done ? ST_DONE : ST_WAIT);
         ST_WAIT:  state_nx = (m.mem_done || tout) ? ST_DONE : ST_WAIT;
         default:  state_nx = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         op_rd   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         tcnt    <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && req) begin
            op_rd   <= m.memRead_in;
            addr_q  <= m.addr_in;
            wdata_q <= m.wdata_in;
            tcnt    <= '0;
            if (m.memRead_in && m.memWrite_in) err_q <= 1'b1;
         end
         if (state == ST_WAIT) tcnt <= tcnt + 1'b1;
         if (fin && op_rd) rdata_q <= m.mem_rdata;
         if (tout) err_q <= 1'b1;
      end
   end
   assign m.mem_rd     = state == ST_ISSUE && op_rd;
   assign m.mem_wr     = state == ST_ISSUE && !op_rd;
   assign m.mem_freeze = state == ST_ISSUE || state == ST_WAIT || (state == ST_IDLE && req);
   assign m.done_pulse = state == ST_DONE;
   assign m.mem_addr   = addr_q;
   assign m.mem_wdata  = wdata_q;
   assign m.rdata_out  = rdata_q;
   assign m.err        = err_q;
   sat_cnt16 u_hit  (.clk(clk), .rst(rst), .en(fin && m.mem_hit),  .q(m.hit_cnt));
   sat_cnt16 u_miss (.clk(clk), .rst(rst), .en(fin && !m.mem_hit), .q(m.miss_cnt));
endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb_mem_stall_ctrl: randomized scoreboard bench for the memory stall controller
module tb_mem_stall_ctrl;
   localparam int TOUT = 64;
   typedef struct {
      int c0, lat, fz, nrd, nwr;
      logic [15:0] addr, wdata, rdata, hit, miss;
      logic err;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0, total = 0, bad = 0;
   int fz = 0, nrd = 0, nwr = 0;
   exp_t q[$];
   logic [15:0] m_rdata, m_hit, m_miss;
   logic m_err;
   mem_stall_if bus();
   mem_stall_ctrl #(.TIMEOUT(TOUT)) dut (.clk(clk), .rst(rst), .m(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst) begin
         fz = 0;
         nrd = 0;
         nwr = 0;
      end else begin
         if (bus.mem_freeze) fz++;
         if (bus.mem_rd) nrd++;
         if (bus.mem_wr) nwr++;
         if ((bus.mem_rd || bus.mem_wr) && q.size() > 0) begin
            chk("mem_addr", bus.mem_addr, q[0].addr);
            if (bus.mem_wr) chk("mem_wdata", bus.mem_wdata, q[0].wdata);
         end
         if (bus.done_pulse) begin
            chk("queue_depth", q.size(), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("rdata_out", bus.rdata_out, e.rdata);
               chk("hit_cnt", bus.hit_cnt, e.hit);
               chk("miss_cnt", bus.miss_cnt, e.miss);
               chk("err", bus.err, e.err);
               chk("latency", cyc - e.c0, e.lat);
               chk("freeze_cycles", fz, e.fz);
               chk("rd_strobes", nrd, e.nrd);
               chk("wr_strobes", nwr, e.nwr);
               chk("freeze_in_done", bus.mem_freeze, 0);
            end
            fz = 0;
            nrd = 0;
            nwr = 0;
         end
      end
   end
   task automatic txn(input bit rd, wr, input logic [15:0] a, wd, rdv,
                      input int s, w, input bit to, hit, bb);
      exp_t e;
      int l;
      l = to ? s + 1 + TOUT : s + 1 + w;
      @(posedge clk); #1;
      if (rd && wr) m_err = 1'b1;
      if (to) m_err = 1'b1;
      else begin
         if (rd) m_rdata = rdv;
         if (hit) m_hit = (m_hit == 16'hFFFF) ? m_hit : m_hit + 16'd1;
         else m_miss = (m_miss == 16'hFFFF) ? m_miss : m_miss + 16'd1;
      end
      e = '{cyc, l + 1, l + 1, rd ? s + 1 : 0, rd ? 0 : s + 1, a, wd, m_rdata, m_hit, m_miss, m_err};
      q.push_back(e);
      bus.memRead_in = rd;
      bus.memWrite_in = wr;
      bus.addr_in = a;
      bus.wdata_in = wd;
      bus.mem_rdata = rdv;
      bus.mem_hit = hit;
      bus.mem_stall = 1'b0;
      bus.mem_done = 1'b0;
      for (int k = 1; k <= l; k++) begin
         @(posedge clk); #1;
         bus.mem_stall = k <= s;
         bus.mem_done = !to && k == l;
      end
      @(posedge clk); #1;
      bus.mem_stall = 1'b0;
      bus.mem_done = 1'b0;
      if (!bb) begin
         bus.memRead_in = 1'b0;
         bus.memWrite_in = 1'b0;
      end
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         bus.memRead_in = 1'b0;
         bus.memWrite_in = 1'b0;
         bus.mem_done = 1'($urandom_range(0, 1));
         bus.mem_hit = 1'($urandom_range(0, 1));
         bus.mem_rdata = 16'($urandom);
      end
   endtask
   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin : stim
      bit rd, bb;
      bus.memRead_in = 1'b0;
      bus.memWrite_in = 1'b0;
      bus.addr_in = '0;
      bus.wdata_in = '0;
      bus.mem_stall = 1'b0;
      bus.mem_done = 1'b0;
      bus.mem_hit = 1'b0;
      bus.mem_rdata = '0;
      m_rdata = '0;
      m_hit = '0;
      m_miss = '0;
      m_err = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_freeze", bus.mem_freeze, 0);
      chk("rst_rd", bus.mem_rd, 0);
      chk("rst_wr", bus.mem_wr, 0);
      chk("rst_done", bus.done_pulse, 0);
      chk("rst_rdata", bus.rdata_out, 0);
      chk("rst_hit", bus.hit_cnt, 0);
      chk("rst_miss", bus.miss_cnt, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      txn(1, 0, 16'h0040, 16'h0000, 16'hBEEF, 0, 0, 0, 1, 0);
      idle(2);
      txn(0, 1, 16'h0080, 16'h1234, 16'h5555, 2, 3, 0, 0, 0);
      idle(1);
      txn(1, 0, 16'h0100, 16'h0000, 16'hA1A1, 0, 2, 0, 1, 1);
      txn(1, 0, 16'h0102, 16'h0000, 16'hB2B2, 1, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         rd = 1'($urandom_range(0, 1));
         bb = 1'($urandom_range(0, 1));
         txn(rd, !rd, 16'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 0, 1'($urandom_range(0, 1)), bb);
         if (!bb) idle(int'($urandom_range(0, 2)));
      end
      idle(3);
      chk("drained_random", q.size(), 0);
      @(posedge clk); #1;
      bus.memRead_in = 1'b1;
      bus.addr_in = 16'h0200;
      bus.mem_stall = 1'b0;
      bus.mem_done = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      bus.memRead_in = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_freeze", bus.mem_freeze, 0);
      chk("abort_rd", bus.mem_rd, 0);
      chk("abort_done", bus.done_pulse, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_freeze_after", bus.mem_freeze, 0);
      chk("abort_hit", bus.hit_cnt, 0);
      chk("abort_miss", bus.miss_cnt, 0);
      chk("abort_err", bus.err, 0);
      chk("abort_rdata", bus.rdata_out, 0);
      m_rdata = '0;
      m_hit = '0;
      m_miss = '0;
      m_err = 1'b0;
      idle(4);
      txn(1, 1, 16'h0300, 16'hDEAD, 16'hC0DE, 1, 1, 0, 1, 0);
      idle(3);
      txn(1, 0, 16'h0400, 16'h0000, 16'h7777, 0, 0, 1, 0, 0);
      idle(2);
      txn(0, 1, 16'h0500, 16'h4321, 16'h9999, 0, 1, 0, 0, 0);
      idle(3);
      chk("drained_final", q.size(), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("err_cleared", bus.err, 0);
      chk("hit_cleared", bus.hit_cnt, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
